// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmit FSM states, baud divisors and frame geometry.
// The receive side reuses the divisor selection so both directions agree on bit time.
package spart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DIV_W      = 16;
    localparam int DIV_4800   = 20833;
    localparam int DIV_9600   = 10417;
    localparam int DIV_19200  = 5208;
    localparam int DIV_38400  = 2604;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    function automatic logic [DIV_W-1:0] select_div(input logic [1:0] cfg,
                                                    input int d4800, input int d9600,
                                                    input int d19200, input int d38400);
        case (cfg)
            2'b00:   return DIV_W'(d4800);
            2'b01:   return DIV_W'(d9600);
            2'b10:   return DIV_W'(d19200);
            default: return DIV_W'(d38400);
        endcase
    endfunction

    function automatic logic [DIV_W-1:0] default_div(input logic [1:0] cfg);
        return select_div(cfg, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
    endfunction

endpackage

// File: rtl/spart_tx_fifo.sv
// Small transmit byte queue: synchronous write, head visible on dout from registered storage.
// full/empty are registered alongside the occupancy count.
module spart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      next_count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        next_count = count;
        case ({do_push, do_pop})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= next_count;
            full  <= (next_count == FULL_CNT);
            empty <= (next_count == '0);
        end
    end

endmodule

// File: rtl/spart_tx_buffer.sv
// CPU-to-RS232 transmit path: byte FIFO drained by an 8N1 serializer at the br_cfg baud rate.
// tx_done_pulse marks the end of the last queued frame.
module spart_tx_buffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_4800   = spart_pkg::DIV_4800,
    parameter int DIV_9600   = spart_pkg::DIV_9600,
    parameter int DIV_19200  = spart_pkg::DIV_19200,
    parameter int DIV_38400  = spart_pkg::DIV_38400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       txd,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       wr_overflow,
    output logic       tx_done_pulse
);
    import spart_pkg::*;

    tx_state_t        state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       sh;
    logic [7:0]       fifo_dout;
    logic             fifo_pop;
    logic             bit_end;

    spart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .full  (tx_full),
        .empty (tx_empty),
        .dout  (fifo_dout)
    );

    assign bit_end  = (baud_cnt == div_q - 1'b1);
    assign fifo_pop = !tx_empty && ((state == IDLE) || (state == STOP && bit_end));

    // A pop always starts a fresh frame, whether from IDLE or straight out of STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            txd           <= 1'b1;
            tx_busy       <= 1'b0;
            wr_overflow   <= 1'b0;
            tx_done_pulse <= 1'b0;
            div_q         <= '0;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            sh            <= '0;
        end else begin
            wr_overflow   <= wr_en & tx_full;
            tx_done_pulse <= 1'b0;
            if (fifo_pop) begin
                sh       <= fifo_dout;
                div_q    <= select_div(br_cfg, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
                baud_cnt <= '0;
                bit_idx  <= '0;
                state    <= START;
                txd      <= 1'b0;
                tx_busy  <= 1'b1;
            end else if (state != IDLE) begin
                if (!bit_end) begin
                    baud_cnt <= baud_cnt + 1'b1;
                end else begin
                    baud_cnt <= '0;
                    case (state)
                        START: begin
                            state <= DATA;
                            txd   <= sh[0];
                        end
                        DATA: begin
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end else begin
                                sh      <= sh >> 1;
                                txd     <= sh[1];
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        default: begin
                            state         <= IDLE;
                            tx_busy       <= 1'b0;
                            tx_done_pulse <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spart_tx_buffer.sv
// Self-checking bench for spart_tx_buffer: directed scenarios plus random traffic,
// compared every cycle against a frame-timeline reference model.
module tb_spart_tx_buffer;

    localparam int DEPTH = 4;
    localparam int D0 = 12;
    localparam int D1 = 8;
    localparam int D2 = 6;
    localparam int D3 = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       txd, tx_full, tx_empty, tx_busy, wr_overflow, tx_done_pulse;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         m_active;
    int         m_t;
    int         m_div;
    logic [7:0] m_byte;
    bit         m_ovf;
    bit         m_done;

    spart_tx_buffer #(
        .FIFO_DEPTH(DEPTH), .DIV_4800(D0), .DIV_9600(D1), .DIV_19200(D2), .DIV_38400(D3)
    ) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .wr_en(wr_en), .wr_data(wr_data),
        .txd(txd), .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .wr_overflow(wr_overflow), .tx_done_pulse(tx_done_pulse)
    );

    always #5 clk = ~clk;

    function automatic int div_of(input logic [1:0] cfg);
        case (cfg)
            2'b00:   return D0;
            2'b01:   return D1;
            2'b10:   return D2;
            default: return D3;
        endcase
    endfunction

    function automatic logic exp_txd();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_t / m_div;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_t = 0;
        m_div = 1;
        m_byte = 8'h00;
        m_ovf = 0;
        m_done = 0;
    endtask

    // One clock edge of the reference: frames last 10 bit times, pops use pre-edge occupancy.
    task automatic model_step();
        bit was_full;
        bit frame_end;
        was_full = (q.size() == DEPTH);
        frame_end = 0;
        m_ovf = 0;
        m_done = 0;
        if (m_active) begin
            m_t++;
            if (m_t == 10 * m_div) frame_end = 1;
        end
        if (!m_active || frame_end) begin
            if (q.size() > 0) begin
                m_byte = q.pop_front();
                m_div = div_of(br_cfg);
                m_t = 0;
                m_active = 1;
            end else begin
                m_done = frame_end;
                m_active = 0;
            end
        end
        if (wr_en) begin
            if (was_full) m_ovf = 1;
            else q.push_back(wr_data);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, ".txd"}, 32'(txd), 32'(exp_txd()));
        checkOutput({tag, ".tx_busy"}, 32'(tx_busy), 32'(m_active));
        checkOutput({tag, ".tx_empty"}, 32'(tx_empty), 32'(q.size() == 0));
        checkOutput({tag, ".tx_full"}, 32'(tx_full), 32'(q.size() == DEPTH));
        checkOutput({tag, ".wr_overflow"}, 32'(wr_overflow), 32'(m_ovf));
        checkOutput({tag, ".tx_done_pulse"}, 32'(tx_done_pulse), 32'(m_done));
    endtask

    task automatic applyStimulus(input string tag, input bit we, input logic [7:0] d, input logic [1:0] cfg);
        wr_en = we;
        wr_data = d;
        br_cfg = cfg;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m_active || q.size() > 0) && n < 3000) begin
            applyStimulus(tag, 1'b0, 8'h00, br_cfg);
            n++;
        end
        checkOutput({tag, ".timeout"}, 32'(n >= 3000), 32'(0));
        applyStimulus(tag, 1'b0, 8'h00, br_cfg);
    endtask

    initial begin
        rst = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        br_cfg = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        applyStimulus("idle", 1'b0, 8'h00, 2'b00);

        applyStimulus("single", 1'b1, 8'hA5, 2'b11);
        wait_idle("single");

        applyStimulus("b2b", 1'b1, 8'h01, 2'b11);
        applyStimulus("b2b", 1'b1, 8'h02, 2'b11);
        applyStimulus("b2b", 1'b1, 8'h03, 2'b11);
        wait_idle("b2b");

        for (int i = 0; i < 6; i++)
            applyStimulus("fill", 1'b1, 8'h10 + 8'(i), 2'b11);
        wait_idle("fill");

        applyStimulus("cfgchg", 1'b1, 8'hFF, 2'b00);
        for (int n = 0; n < 200 && !(m_active && m_t / m_div >= 4); n++)
            applyStimulus("cfgchg", 1'b0, 8'h00, 2'b00);
        applyStimulus("cfgchg", 1'b0, 8'h00, 2'b11);
        wait_idle("cfgchg");

        applyStimulus("rstmid", 1'b1, 8'h55, 2'b01);
        for (int n = 0; n < 200 && !(m_active && m_t / m_div >= 4); n++)
            applyStimulus("rstmid", 1'b0, 8'h00, 2'b01);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rstasync");
        repeat (3) begin
            @(negedge clk);
            check_all("rsthold");
        end
        rst = 1'b1;
        for (int i = 0; i < 40; i++)
            applyStimulus("postrst", 1'b0, 8'h00, 2'b01);

        applyStimulus("stopwr", 1'b1, 8'hA1, 2'b10);
        applyStimulus("stopwr", 1'b1, 8'hB2, 2'b10);
        for (int n = 0; n < 200 && !(m_active && m_t == 10 * m_div - 1); n++)
            applyStimulus("stopwr", 1'b0, 8'h00, 2'b10);
        applyStimulus("stopwr", 1'b1, 8'hC3, 2'b10);
        wait_idle("stopwr");

        for (int i = 0; i < 2000; i++) begin
            logic [1:0] cfg;
            cfg = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : br_cfg;
            applyStimulus("rand", $urandom_range(0, 24) == 0, 8'($urandom), cfg);
        end
        wait_idle("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
